// File: rtl/mem_access_controller_pkg.sv
// Shared MEM-stage definitions: load/store opcodes, sequencer states,
// access sizes and small decode helpers used by the controller.
package mem_access_controller_pkg;

    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LHU = 6'b100101;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_SB  = 6'b101000;
    localparam logic [5:0] OP_SH  = 6'b101001;
    localparam logic [5:0] OP_SW  = 6'b101011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        BYTE = 2'd0,
        HALF = 2'd1,
        WORD = 2'd2
    } size_e;

    function automatic logic is_load(input logic [5:0] op);
        return op inside {OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW};
    endfunction

    function automatic logic is_store(input logic [5:0] op);
        return op inside {OP_SB, OP_SH, OP_SW};
    endfunction

    function automatic size_e acc_size(input logic [5:0] op);
        size_e s;
        case (op)
            OP_LB, OP_LBU, OP_SB: s = BYTE;
            OP_LH, OP_LHU, OP_SH: s = HALF;
            default:              s = WORD;
        endcase
        return s;
    endfunction

    function automatic logic is_signed(input logic [5:0] op);
        return (op == OP_LB) || (op == OP_LH);
    endfunction

endpackage

// File: rtl/mem_access_controller_if.sv
// Data-memory req/ack bus. master = controller side, slave = memory side.
// Signals: mem_req, mem_we, mem_addr, mem_byteen, mem_wdata, mem_ack, mem_rdata.
interface mem_access_controller_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_byteen;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_byteen, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_byteen, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/mem_access_controller_load_data_extender.sv
// Combinational load alignment: picks the byte/halfword lane from rdata
// using addr[1:0] and sign/zero-extends it by opcode. Ports: rdata, lo, opcode -> data.
module load_data_extender
    import mem_access_controller_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  lo,
    input  logic [5:0]  opcode,
    output logic [31:0] data
);
    logic [7:0]  b;
    logic [15:0] h;
    logic        sx;

    always_comb begin
        b    = rdata[7:0];
        h    = rdata[15:0];
        sx   = is_signed(opcode);
        data = rdata;
        unique case (lo)
            2'd0: b = rdata[7:0];
            2'd1: b = rdata[15:8];
            2'd2: b = rdata[23:16];
            2'd3: b = rdata[31:24];
        endcase
        if (lo[1]) h = rdata[31:16];
        unique case (acc_size(opcode))
            BYTE:    data = {{24{sx & b[7]}}, b};
            HALF:    data = {{16{sx & h[15]}}, h};
            default: data = rdata;
        endcase
    end
endmodule

// File: rtl/mem_access_controller.sv
// MEM-stage sequencer to a variable-latency data memory with watchdog.
// Ports: clk, reset (async active-low), valid, instruction, addr, store_data,
// flush -> stall, load_data, bus_err, mem (master bus); adel/ades when
// MISALIGN_CHECK_EN is defined.
module mem_access_controller
    import mem_access_controller_pkg::*;
#(
    parameter int MAX_WAIT = 255
)(
    input  logic        clk,
    input  logic        reset,
    input  logic        valid,
    input  logic [31:0] instruction,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    input  logic        flush,
    output logic        stall,
    output logic [31:0] load_data,
    output logic        bus_err,
`ifdef MISALIGN_CHECK_EN
    output logic        adel,
    output logic        ades,
`endif
    mem_access_controller_if.master mem
);
    localparam int CW = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(MAX_WAIT - 1);

    state_e      state_q, state_d;
    logic        req_q, req_d, we_q, we_d;
    logic [31:0] addr_q, addr_d, wd_q, wd_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] ld_q, ld_d, ext_data;
    logic        berr_q, berr_d;
    logic [5:0]  op_q, op_d;
    logic [1:0]  lo_q, lo_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic        fl_q, fl_d, fl_now;
    logic [5:0]  opcode;
    logic        ld_op, st_op, mem_op;
    logic [3:0]  be_new;
    logic [31:0] wd_new;
    logic        unused_instr;
`ifdef MISALIGN_CHECK_EN
    logic        adel_q, adel_d, ades_q, ades_d, misal;
`endif

    assign opcode       = instruction[31:26];
    assign unused_instr = ^instruction[25:0];
    assign ld_op        = is_load(opcode);
    assign st_op        = is_store(opcode);
    assign mem_op       = ld_op | st_op;
    assign fl_now       = fl_q | flush;

    // A flushed access keeps its handshake but must not hold the pipeline.
    assign stall = reset & valid & mem_op & (state_q != DONE)
                 & ~flush & ~((state_q == REQ) & fl_q);

    always_comb begin
        be_new = 4'b0000;
        wd_new = store_data;
        if (st_op) begin
            unique case (acc_size(opcode))
                BYTE: begin
                    be_new = 4'b0001 << addr[1:0];
                    wd_new = {4{store_data[7:0]}};
                end
                HALF: begin
                    be_new = addr[1] ? 4'b1100 : 4'b0011;
                    wd_new = {2{store_data[15:0]}};
                end
                default: be_new = 4'b1111;
            endcase
        end
    end

`ifdef MISALIGN_CHECK_EN
    always_comb begin
        misal = 1'b0;
        unique case (acc_size(opcode))
            HALF:    misal = addr[0];
            WORD:    misal = |addr[1:0];
            default: misal = 1'b0;
        endcase
    end
`endif

    load_data_extender u_ext (
        .rdata  (mem.mem_rdata),
        .lo     (lo_q),
        .opcode (op_q),
        .data   (ext_data)
    );

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        be_d    = be_q;
        wd_d    = wd_q;
        ld_d    = ld_q;
        berr_d  = 1'b0;
        op_d    = op_q;
        lo_d    = lo_q;
        cnt_d   = cnt_q;
        fl_d    = fl_q;
`ifdef MISALIGN_CHECK_EN
        adel_d  = 1'b0;
        ades_d  = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                fl_d  = 1'b0;
                cnt_d = '0;
                if (valid && mem_op && !flush) begin
                    op_d = opcode;
                    lo_d = addr[1:0];
`ifdef MISALIGN_CHECK_EN
                    if (misal) begin
                        adel_d  = ld_op;
                        ades_d  = st_op;
                        ld_d    = '0;
                        state_d = DONE;
                    end else
`endif
                    begin
                        req_d   = 1'b1;
                        we_d    = st_op;
                        addr_d  = {addr[31:2], 2'b00};
                        be_d    = be_new;
                        wd_d    = wd_new;
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                if (flush) fl_d = 1'b1;
                // Ack wins over a watchdog expiry in the same cycle.
                if (mem.mem_ack) begin
                    req_d   = 1'b0;
                    fl_d    = 1'b0;
                    if (!fl_now) ld_d = ext_data;
                    state_d = fl_now ? IDLE : DONE;
                end else if (cnt_q == CNT_LAST) begin
                    req_d   = 1'b0;
                    fl_d    = 1'b0;
                    berr_d  = 1'b1;
                    if (!fl_now) ld_d = '0;
                    state_d = fl_now ? IDLE : DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            be_q    <= '0;
            wd_q    <= '0;
            ld_q    <= '0;
            berr_q  <= 1'b0;
            op_q    <= '0;
            lo_q    <= '0;
            cnt_q   <= '0;
            fl_q    <= 1'b0;
`ifdef MISALIGN_CHECK_EN
            adel_q  <= 1'b0;
            ades_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wd_q    <= wd_d;
            ld_q    <= ld_d;
            berr_q  <= berr_d;
            op_q    <= op_d;
            lo_q    <= lo_d;
            cnt_q   <= cnt_d;
            fl_q    <= fl_d;
`ifdef MISALIGN_CHECK_EN
            adel_q  <= adel_d;
            ades_q  <= ades_d;
`endif
        end
    end

    assign mem.mem_req    = req_q;
    assign mem.mem_we     = we_q;
    assign mem.mem_addr   = addr_q;
    assign mem.mem_byteen = be_q;
    assign mem.mem_wdata  = wd_q;
    assign load_data      = ld_q;
    assign bus_err        = berr_q;
`ifdef MISALIGN_CHECK_EN
    assign adel           = adel_q;
    assign ades           = ades_q;
`endif

endmodule

// File: tb/tb_mem_access_controller.sv
// Self-checking bench for mem_access_controller (MAX_WAIT=8).
// Scoreboard of expected access results; memory model answers with a set ack delay.
module tb_mem_access_controller;
    import mem_access_controller_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        valid = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] instruction = '0;
    logic [31:0] addr = '0;
    logic [31:0] store_data = '0;
    logic        stall, bus_err;
    logic [31:0] load_data;
`ifdef MISALIGN_CHECK_EN
    logic        adel, ades;
`endif

    mem_access_controller_if bus ();

    always #5 clk = ~clk;

    mem_access_controller #(.MAX_WAIT(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .valid       (valid),
        .instruction (instruction),
        .addr        (addr),
        .store_data  (store_data),
        .flush       (flush),
        .stall       (stall),
        .load_data   (load_data),
        .bus_err     (bus_err),
`ifdef MISALIGN_CHECK_EN
        .adel        (adel),
        .ades        (ades),
`endif
        .mem         (bus)
    );

    typedef struct {
        logic [31:0] ld;
        int          stl;
        int          req;
        logic [3:0]  be;
        logic        we;
        logic [31:0] wd;
        logic [31:0] ma;
    } exp_t;

    exp_t exp_q[$];
    int checks = 0;
    int failures = 0;

    int          o_stall, o_stall_fl, o_req;
    logic        o_idle_stall, o_we, o_berr, o_berr_next, o_req_done;
    logic        o_adel, o_ades;
    logic [3:0]  o_be;
    logic [31:0] o_ma, o_wd, o_ld;

    task automatic run_op(input logic [5:0] op, input logic [31:0] a,
                          input logic [31:0] sd, input logic [31:0] rd,
                          input int ack_at, input int flush_at,
                          input bit hold);
        int  rq;
        bit  done, fl;
        rq = 0; done = 0; fl = 0;
        o_stall = 0; o_stall_fl = 0; o_idle_stall = 0;
        o_we = 0; o_be = 0; o_ma = 0; o_wd = 0; o_ld = 0;
        o_berr = 0; o_berr_next = 0; o_req_done = 0;
        o_adel = 0; o_ades = 0;
        @(negedge clk);
        valid = 1'b1;
        instruction = {op, 26'h0};
        addr = a;
        store_data = sd;
        for (int c = 0; c < 60 && !done; c++) begin
            if (c > 0) @(negedge clk);
            bus.mem_ack = 1'b0;
            bus.mem_rdata = 32'h0BAD_0BAD;
            flush = 1'b0;
            if (bus.mem_req) begin
                rq++;
                if (rq == 1) begin
                    o_we = bus.mem_we; o_be = bus.mem_byteen;
                    o_ma = bus.mem_addr; o_wd = bus.mem_wdata;
                end
                if (rq == ack_at) begin
                    bus.mem_ack = 1'b1;
                    bus.mem_rdata = rd;
                end
                if (rq == flush_at) begin
                    flush = 1'b1;
                    fl = 1;
                end
            end
            #1;
            if (fl && !bus.mem_req && rq > 0) begin
                o_idle_stall = stall;
                o_ld = load_data;
                done = 1;
            end else if (!fl && !stall) begin
                o_ld = load_data;
                o_berr = bus_err;
                o_req_done = bus.mem_req;
`ifdef MISALIGN_CHECK_EN
                o_adel = adel;
                o_ades = ades;
`endif
                done = 1;
            end else begin
                if (stall) o_stall++;
                if (stall && fl) o_stall_fl++;
            end
        end
        o_req = rq;
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL run_bound op=%b got=timeout exp=done", op);
        end
        if (!hold) begin
            #1;
            valid = 1'b0;
            flush = 1'b0;
            bus.mem_ack = 1'b0;
            @(negedge clk);
            #1;
            o_berr_next = bus_err;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        valid = 1'b1;
        instruction = {OP_LW, 26'h0};
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (stall !== 1'b0) begin
            failures++;
            $display("FAIL rst_stall got=%b exp=0", stall);
        end
        checks++;
        if (bus.mem_req !== 1'b0) begin
            failures++;
            $display("FAIL rst_req got=%b exp=0", bus.mem_req);
        end
        checks++;
        if ({bus.mem_we, bus.mem_byteen, bus.mem_addr, bus.mem_wdata} !== '0) begin
            failures++;
            $display("FAIL rst_bus got=%h exp=0",
                     {bus.mem_we, bus.mem_byteen, bus.mem_addr, bus.mem_wdata});
        end
        checks++;
        if (load_data !== 32'h0) begin
            failures++;
            $display("FAIL rst_ld got=%h exp=0", load_data);
        end
        checks++;
        if (bus_err !== 1'b0) begin
            failures++;
            $display("FAIL rst_berr got=%b exp=0", bus_err);
        end
        valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_lw();
        exp_t e;
        exp_q.push_back('{32'hDEAD_BEEF, 2, 1, 4'b0000, 1'b0, 32'h0, 32'h1004});
        run_op(OP_LW, 32'h0000_1004, 32'h0, 32'hDEAD_BEEF, 1, 0, 0);
        e = exp_q.pop_front();
        checks++;
        if (o_ma !== e.ma) begin
            failures++; $display("FAIL lw_addr got=%h exp=%h", o_ma, e.ma);
        end
        checks++;
        if ({o_we, o_be} !== {e.we, e.be}) begin
            failures++; $display("FAIL lw_we_be got=%b exp=%b", {o_we, o_be}, {e.we, e.be});
        end
        checks++;
        if (o_stall !== e.stl) begin
            failures++; $display("FAIL lw_stall got=%0d exp=%0d", o_stall, e.stl);
        end
        checks++;
        if (o_ld !== e.ld) begin
            failures++; $display("FAIL lw_data got=%h exp=%h", o_ld, e.ld);
        end
    endtask

    task automatic test_flush();
        exp_t e;
        exp_q.push_back('{32'hDEAD_BEEF, 1, 5, 4'b0, 1'b0, 32'h0, 32'h1008});
        run_op(OP_LW, 32'h0000_1008, 32'h0, 32'h1111_1111, 5, 2, 0);
        e = exp_q.pop_front();
        checks++;
        if (o_req !== e.req) begin
            failures++; $display("FAIL flush_req_cycles got=%0d exp=%0d", o_req, e.req);
        end
        checks++;
        if (o_stall_fl !== 0) begin
            failures++; $display("FAIL flush_stall got=%0d exp=0", o_stall_fl);
        end
        checks++;
        if (o_idle_stall !== 1'b1) begin
            failures++; $display("FAIL flush_no_done got=%b exp=1", o_idle_stall);
        end
        checks++;
        if (o_ld !== e.ld) begin
            failures++; $display("FAIL flush_ld got=%h exp=%h", o_ld, e.ld);
        end
    endtask

    task automatic test_byte_loads();
        exp_t e;
        exp_q.push_back('{32'hFFFF_FF80, 5, 4, 4'b0, 1'b0, 32'h0, 32'h2000});
        run_op(OP_LB, 32'h0000_2003, 32'h0, 32'h80FF_FF7F, 4, 0, 0);
        e = exp_q.pop_front();
        checks++;
        if (o_ld !== e.ld) begin
            failures++; $display("FAIL lb_data got=%h exp=%h", o_ld, e.ld);
        end
        checks++;
        if (o_stall !== e.stl) begin
            failures++; $display("FAIL lb_stall got=%0d exp=%0d", o_stall, e.stl);
        end
        exp_q.push_back('{32'h0000_0080, 5, 4, 4'b0, 1'b0, 32'h0, 32'h2000});
        run_op(OP_LBU, 32'h0000_2003, 32'h0, 32'h80FF_FF7F, 4, 0, 0);
        e = exp_q.pop_front();
        checks++;
        if (o_ld !== e.ld) begin
            failures++; $display("FAIL lbu_data got=%h exp=%h", o_ld, e.ld);
        end
        exp_q.push_back('{32'h0000_007F, 2, 1, 4'b0, 1'b0, 32'h0, 32'h2000});
        run_op(OP_LB, 32'h0000_2000, 32'h0, 32'h80FF_FF7F, 1, 0, 0);
        e = exp_q.pop_front();
        checks++;
        if (o_ld !== e.ld) begin
            failures++; $display("FAIL lb0_data got=%h exp=%h", o_ld, e.ld);
        end
    endtask

    task automatic test_half_loads();
        exp_t e;
        exp_q.push_back('{32'hFFFF_8001, 3, 2, 4'b0, 1'b0, 32'h0, 32'h2400});
        run_op(OP_LH, 32'h0000_2402, 32'h0, 32'h8001_1234, 2, 0, 0);
        e = exp_q.pop_front();
        checks++;
        if (o_ld !== e.ld) begin
            failures++; $display("FAIL lh_data got=%h exp=%h", o_ld, e.ld);
        end
        exp_q.push_back('{32'h0000_9234, 2, 1, 4'b0, 1'b0, 32'h0, 32'h2400});
        run_op(OP_LHU, 32'h0000_2400, 32'h0, 32'h8001_9234, 1, 0, 0);
        e = exp_q.pop_front();
        checks++;
        if (o_ld !== e.ld) begin
            failures++; $display("FAIL lhu_data got=%h exp=%h", o_ld, e.ld);
        end
    endtask

    task automatic test_stores();
        exp_t e;
        exp_q.push_back('{32'h0, 3, 2, 4'b1100, 1'b1, 32'hABCD_ABCD, 32'h4000});
        run_op(OP_SH, 32'h0000_4002, 32'h1234_ABCD, 32'h0, 2, 0, 0);
        e = exp_q.pop_front();
        checks++;
        if (o_we !== e.we) begin
            failures++; $display("FAIL sh_we got=%b exp=%b", o_we, e.we);
        end
        checks++;
        if (o_be !== e.be) begin
            failures++; $display("FAIL sh_be got=%b exp=%b", o_be, e.be);
        end
        checks++;
        if (o_wd !== e.wd) begin
            failures++; $display("FAIL sh_wdata got=%h exp=%h", o_wd, e.wd);
        end
        checks++;
        if (o_ma !== e.ma) begin
            failures++; $display("FAIL sh_addr got=%h exp=%h", o_ma, e.ma);
        end
        exp_q.push_back('{32'h0, 2, 1, 4'b0010, 1'b1, 32'hCDCD_CDCD, 32'h4000});
        run_op(OP_SB, 32'h0000_4001, 32'h1234_ABCD, 32'h0, 1, 0, 0);
        e = exp_q.pop_front();
        checks++;
        if (o_be !== e.be) begin
            failures++; $display("FAIL sb_be got=%b exp=%b", o_be, e.be);
        end
        checks++;
        if (o_wd !== e.wd) begin
            failures++; $display("FAIL sb_wdata got=%h exp=%h", o_wd, e.wd);
        end
    endtask

    task automatic test_timeout();
        exp_t e;
        exp_q.push_back('{32'h0, 9, 8, 4'b0, 1'b0, 32'h0, 32'h6000});
        run_op(OP_LW, 32'h0000_6000, 32'h0, 32'h0, 0, 0, 0);
        e = exp_q.pop_front();
        checks++;
        if (o_req !== e.req) begin
            failures++; $display("FAIL wd_req_cycles got=%0d exp=%0d", o_req, e.req);
        end
        checks++;
        if ({o_berr, o_berr_next} !== 2'b10) begin
            failures++; $display("FAIL wd_berr_pulse got=%b exp=10", {o_berr, o_berr_next});
        end
        checks++;
        if (o_ld !== e.ld) begin
            failures++; $display("FAIL wd_ld got=%h exp=%h", o_ld, e.ld);
        end
        checks++;
        if (o_req_done !== 1'b0) begin
            failures++; $display("FAIL wd_req_drop got=%b exp=0", o_req_done);
        end
        checks++;
        if (o_stall !== e.stl) begin
            failures++; $display("FAIL wd_stall got=%0d exp=%0d", o_stall, e.stl);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        exp_q.push_back('{32'h0, 2, 1, 4'b1111, 1'b1, 32'h0102_0304, 32'h5000});
        run_op(OP_SW, 32'h0000_5000, 32'h0102_0304, 32'h0, 1, 0, 1);
        e = exp_q.pop_front();
        checks++;
        if ({o_we, o_be, o_wd} !== {e.we, e.be, e.wd}) begin
            failures++;
            $display("FAIL sw_lanes got=%h exp=%h", {o_we, o_be, o_wd}, {e.we, e.be, e.wd});
        end
        exp_q.push_back('{32'h0102_0304, 2, 1, 4'b0, 1'b0, 32'h0, 32'h5000});
        run_op(OP_LW, 32'h0000_5000, 32'h0, 32'h0102_0304, 1, 0, 0);
        e = exp_q.pop_front();
        checks++;
        if (o_stall !== e.stl) begin
            failures++; $display("FAIL b2b_stall got=%0d exp=%0d", o_stall, e.stl);
        end
        checks++;
        if (o_ld !== e.ld) begin
            failures++; $display("FAIL b2b_data got=%h exp=%h", o_ld, e.ld);
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        @(negedge clk);
        valid = 1'b1;
        instruction = {OP_LW, 26'h0};
        addr = 32'h0000_3000;
        bus.mem_ack = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (bus.mem_req !== 1'b1) begin
            failures++; $display("FAIL rmid_req_before got=%b exp=1", bus.mem_req);
        end
        reset = 1'b0;
        #1;
        checks++;
        if ({bus.mem_req, stall} !== 2'b00) begin
            failures++; $display("FAIL rmid_async got=%b exp=00", {bus.mem_req, stall});
        end
        @(negedge clk);
        valid = 1'b0;
        reset = 1'b1;
        exp_q.push_back('{32'hCAFE_F00D, 2, 1, 4'b0, 1'b0, 32'h0, 32'h3008});
        run_op(OP_LW, 32'h0000_3008, 32'h0, 32'hCAFE_F00D, 1, 0, 0);
        e = exp_q.pop_front();
        checks++;
        if (o_stall !== e.stl) begin
            failures++; $display("FAIL rmid_restart_stall got=%0d exp=%0d", o_stall, e.stl);
        end
        checks++;
        if (o_ld !== e.ld) begin
            failures++; $display("FAIL rmid_restart_ld got=%h exp=%h", o_ld, e.ld);
        end
    endtask

`ifdef MISALIGN_CHECK_EN
    task automatic test_misalign();
        run_op(OP_LW, 32'h0000_7002, 32'h0, 32'h0, 1, 0, 0);
        checks++;
        if ({o_req == 0, o_adel, o_ades} !== 3'b110) begin
            failures++;
            $display("FAIL mis_lw got=%b exp=110", {o_req == 0, o_adel, o_ades});
        end
        checks++;
        if (o_ld !== 32'h0) begin
            failures++; $display("FAIL mis_lw_ld got=%h exp=0", o_ld);
        end
        run_op(OP_SH, 32'h0000_7001, 32'h0, 32'h0, 1, 0, 0);
        checks++;
        if ({o_req == 0, o_adel, o_ades} !== 3'b101) begin
            failures++;
            $display("FAIL mis_sh got=%b exp=101", {o_req == 0, o_adel, o_ades});
        end
    endtask
`endif

    initial begin
        bus.mem_ack = 1'b0;
        bus.mem_rdata = '0;
        test_reset();
        test_lw();
        test_flush();
        test_byte_loads();
        test_half_loads();
        test_stores();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
`ifdef MISALIGN_CHECK_EN
        test_misalign();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_access_controller.md
Name: mem_access_controller

Overview:
- MEM-stage sequencer between the pipeline and a variable-latency data memory with a req/ack handshake.
- Decodes the MEM-stage instruction as load or store and holds the pipeline (stall) while the access is outstanding.
- Drives byte lanes and write data for sb/sh/sw, and aligns and extends read data for lb/lbu/lh/lhu/lw.
- Has a watchdog so a memory that never acknowledges cannot hang the core.

Parameters:
- MAX_WAIT, 255: maximum number of cycles in REQ without mem_ack before a bus error (must be at least 1).

Ports:
- clk  in  1  clock, rising-edge
- reset  in  1  asynchronous, active-low reset
- valid  in  1  MEM-stage instruction valid
- instruction  in  32  MEM-stage instruction; opcode is [31:26]
- addr  in  32  effective byte address
- store_data  in  32  rt value for stores
- flush  in  1  discard the current MEM-stage instruction
- stall  out  1  freeze stages up to and including MEM
- load_data  out  32  extended load result, valid in DONE
- bus_err  out  1  one-cycle pulse on watchdog expiry
- mem_req  out  1  request; held until ack
- mem_we  out  1  1 = write
- mem_addr  out  32  {addr[31:2],2'b00}
- mem_byteen  out  4  write byte enables
- mem_wdata  out  32  lane-replicated store data
- mem_ack  in  1  access complete; mem_rdata valid this cycle
- mem_rdata  in  32  read word

Behaviour:
- Opcode decode:
  - Loads: lb 100000, lbu 100100, lh 100001, lhu 100101, lw 100011.
  - Stores: sb 101000, sh 101001, sw 101011.
  - Any other opcode is a non-memory op, and the block stays passive (stall=0).
- Reset (asynchronous, while reset=0):
  - state=IDLE, mem_req=0, mem_we=0, mem_byteen=0, mem_addr=0, mem_wdata=0, load_data=0, bus_err=0, wait counter=0.
  - stall=0.
  - An access in flight is abandoned; the memory must tolerate the dropped request.
- State machine (IDLE, REQ, DONE):
  - IDLE: if valid & mem_op & ~flush, register addr, byteen, wdata and we, then go to REQ.
  - REQ: mem_req=1 with all outputs stable.
    - On mem_ack: capture extended rdata into load_data; go to DONE, or to IDLE if a flush was latched.
    - Counter reaches MAX_WAIT without ack: drop mem_req, pulse bus_err, load_data=0, go to DONE.
  - DONE: single cycle, then IDLE.
- stall = valid & mem_op & (state != DONE). It is combinational; all other outputs are registered.
- Fastest access has the instruction in MEM for 3 cycles (IDLE, REQ with ack in its first cycle, DONE).
- Flush:
  - In IDLE: no request is issued.
  - In REQ: the handshake still completes (ack or timeout), the result is discarded and DONE is skipped. stall stays low from the flush cycle onward.
- Store lanes:
  - sb: byteen = 1<<addr[1:0], wdata = {4{rt[7:0]}}.
  - sh: byteen = addr[1] ? 1100 : 0011, wdata = {2{rt[15:0]}}.
  - sw: byteen = 1111, wdata = rt.
  - Loads: byteen = 0000.
- Load extension:
  - Byte lane selected by addr[1:0], halfword lane by addr[1].
  - lb/lh sign-extend; lbu/lhu zero-extend; lw passes the word.
- Back-to-back memory ops: after DONE, the next instruction is seen in IDLE, so there is one bubble cycle in which stall=1.
- A simultaneous ack and watchdog expiry counts as ack.

Optional Feature:
- Macro: MISALIGN_CHECK_EN.
- With it defined:
  - A misaligned access (lh/lhu/sh with addr[0]=1, lw/sw with addr[1:0]!=0) issues no request and goes IDLE→DONE.
  - Extra outputs adel/ades (1 bit each) pulse in DONE for a misaligned load or store respectively; load_data=0.
- Without it:
  - Low address bits below the access width are ignored (halfword uses addr[1] only, word ignores addr[1:0]).
  - The adel/ades ports are absent.

Decomposition:
- Shared package: opcode constants (reused by the existing load/store detector), the IDLE/REQ/DONE encoding, and access-size codes (BYTE, HALF, WORD).
- One sub-module, load_data_extender: combinational lane select and sign/zero extension from rdata, addr[1:0] and opcode.

Test Plan:
- lw, addr 0x0000_1004, ack in the first REQ cycle, rdata 0xDEADBEEF → mem_addr 0x1004, stall high for 2 cycles, load_data 0xDEADBEEF in DONE.
- lb, addr 0x...03, rdata 0x80FF_FF7F, ack after 4 cycles → load_data 0xFFFF_FF80; same access with lbu → 0x0000_0080.
- sh, addr 0x...02, rt 0x1234_ABCD → mem_we=1, byteen 1100, wdata 0xABCD_ABCD; sb at addr 0x...01 → byteen 0010, wdata 0xCDCD_CDCD.
- MAX_WAIT=8, ack never asserted → mem_req drops after 8 REQ cycles, bus_err one-cycle pulse, load_data 0, pipeline released.
- flush in the 2nd REQ cycle, ack 3 cycles later → mem_req held until ack, stall low from the flush cycle, no DONE, load_data unchanged.
- reset asserted mid-REQ → mem_req and stall fall asynchronously, state IDLE; with MISALIGN_CHECK_EN, lw at 0x...02 → no mem_req, adel pulse.
